// File: rtl/cache_lru_table.sv
// cache_lru_table: per-set tree pseudo-LRU state with registered lookup, write-first bypass and flush sweep.
module cache_lru_table #(
  parameter int NSETS   = 256,
  parameter int WAYS    = 2,
  parameter int INDEX_W = $clog2(NSETS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [WAYS-2:0]    rd_lru,
  output logic [WAYS-1:0]    rd_victim,
  input  logic               upd_en,
  input  logic [INDEX_W-1:0] upd_index,
  input  logic [WAYS-1:0]    upd_way,
  input  logic               flush_req,
  output logic               flush_busy
);
  localparam int LW = WAYS - 1;
  localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NSETS - 1);
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [LW-1:0] table_q [NSETS];
  logic [LW-1:0] upd_lru, rd_lru_q, rd_lru_d;
  logic rd_valid_q, upd_ok;
  assign upd_ok = upd_en && state_q == IDLE && $onehot(upd_way);
  if (WAYS == 2) begin : g_w2
    assign upd_lru   = upd_way[1];
    assign rd_victim = rd_lru_q[0] ? 2'b01 : 2'b10;
  end else begin : g_w4
    logic [LW-1:0] cur_lru;
    logic w1, w0;
    assign cur_lru   = table_q[upd_index];
    assign w1        = upd_way[2] | upd_way[3];
    assign w0        = upd_way[1] | upd_way[3];
    // only the touched subtree bit changes; the other half keeps its history
    assign upd_lru   = w1 ? {w0, cur_lru[1], 1'b1} : {cur_lru[2], w0, 1'b0};
    assign rd_victim = rd_lru_q[0] ? (rd_lru_q[1] ? 4'b0001 : 4'b0010)
                                   : (rd_lru_q[2] ? 4'b0100 : 4'b1000);
  end
  assign rd_lru_d = state_q == SWEEP ? '0 :
                    (upd_ok && upd_index == rd_index) ? upd_lru : table_q[rd_index];
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (flush_req ? SWEEP : IDLE) : (cnt_q == LAST ? IDLE : SWEEP);
    cnt_d   = state_q == SWEEP ? cnt_q + INDEX_W'(1) : '0;
  end
  always_comb begin
    flush_busy = state_q == SWEEP;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_lru_q   <= '0;
      for (int i = 0; i < NSETS; i++) table_q[i] <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_lru_q <= rd_lru_d;
      if (state_q == SWEEP) table_q[cnt_q] <= '0;
      else if (upd_ok) table_q[upd_index] <= upd_lru;
    end
  end
  assign rd_valid = rd_valid_q;
  assign rd_lru   = rd_lru_q;
endmodule

// File: tb/tb_cache_lru_table.sv
// tb_cache_lru_table: directed checks of a 2-way and a 4-way LRU table, 8 sets each.
module tb_cache_lru_table;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       a_rd_en = 0, a_upd_en = 0, a_flush = 0;
  logic [2:0] a_rd_idx = 0, a_upd_idx = 0;
  logic [1:0] a_upd_way = 0;
  logic       a_valid, a_busy;
  logic [0:0] a_lru;
  logic [1:0] a_victim;
  logic       b_rd_en = 0, b_upd_en = 0, b_flush = 0;
  logic [2:0] b_rd_idx = 0, b_upd_idx = 0;
  logic [3:0] b_upd_way = 0;
  logic       b_valid, b_busy;
  logic [2:0] b_lru;
  logic [3:0] b_victim;
  int checks = 0;
  int errors = 0;
  cache_lru_table #(.NSETS(8), .WAYS(2)) u_a (
    .clock(clk), .reset(rst_n), .rd_en(a_rd_en), .rd_index(a_rd_idx), .rd_valid(a_valid),
    .rd_lru(a_lru), .rd_victim(a_victim), .upd_en(a_upd_en), .upd_index(a_upd_idx),
    .upd_way(a_upd_way), .flush_req(a_flush), .flush_busy(a_busy));
  cache_lru_table #(.NSETS(8), .WAYS(4)) u_b (
    .clock(clk), .reset(rst_n), .rd_en(b_rd_en), .rd_index(b_rd_idx), .rd_valid(b_valid),
    .rd_lru(b_lru), .rd_victim(b_victim), .upd_en(b_upd_en), .upd_index(b_upd_idx),
    .upd_way(b_upd_way), .flush_req(b_flush), .flush_busy(b_busy));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic a_upd(input logic [2:0] idx, input logic [1:0] w);
    a_upd_en = 1; a_upd_idx = idx; a_upd_way = w;
    step();
    a_upd_en = 0;
  endtask
  task automatic a_rd(input logic [2:0] idx);
    a_rd_en = 1; a_rd_idx = idx;
    step();
    a_rd_en = 0;
  endtask
  task automatic b_upd(input logic [2:0] idx, input logic [3:0] w);
    b_upd_en = 1; b_upd_idx = idx; b_upd_way = w;
    step();
    b_upd_en = 0;
  endtask
  task automatic b_rd(input logic [2:0] idx);
    b_rd_en = 1; b_rd_idx = idx;
    step();
    b_rd_en = 0;
  endtask
  initial begin
    step();
    step();
    rst_n = 1;
    chk("rst_valid", a_valid, 0);
    chk("rst_lru", a_lru, 0);
    chk("rst_victim2", a_victim, 2'b10);
    chk("rst_busy", a_busy, 0);
    chk("rst_victim4", b_victim, 4'b1000);
    a_rd(5);
    chk("rd5_valid", a_valid, 1);
    chk("rd5_lru", a_lru, 0);
    chk("rd5_victim", a_victim, 2'b10);
    step();
    chk("valid_pulse", a_valid, 0);
    a_upd(5, 2'b10);
    a_rd(5);
    chk("w1_lru", a_lru, 1);
    chk("w1_victim", a_victim, 2'b01);
    step();
    chk("hold_lru", a_lru, 1);
    a_upd(5, 2'b01);
    a_rd(5);
    chk("w0_lru", a_lru, 0);
    chk("w0_victim", a_victim, 2'b10);
    a_rd_en = 1; a_rd_idx = 6; a_upd_en = 1; a_upd_idx = 6; a_upd_way = 2'b10;
    step();
    a_rd_en = 0; a_upd_en = 0;
    chk("bypass_lru", a_lru, 1);
    chk("bypass_victim", a_victim, 2'b01);
    a_upd(6, 2'b00);
    a_rd(6);
    chk("zero_way_ignored", a_lru, 1);
    a_upd(6, 2'b01);
    a_upd(6, 2'b11);
    a_rd(6);
    chk("multi_way_ignored", a_lru, 0);
    b_upd(3, 4'b0001);
    b_rd(3);
    chk("b_t0", b_lru, 3'b000);
    b_upd(3, 4'b0010);
    b_rd(3);
    chk("b_t1", b_lru, 3'b010);
    chk("b_t1_victim", b_victim, 4'b1000);
    b_upd(3, 4'b0100);
    b_rd(3);
    chk("b_t2", b_lru, 3'b011);
    chk("b_t2_victim", b_victim, 4'b0001);
    b_upd(3, 4'b1000);
    b_rd(3);
    chk("b_t3", b_lru, 3'b111);
    chk("b_t3_victim", b_victim, 4'b0001);
    b_upd(3, 4'b0001);
    b_rd(3);
    chk("b_t0_again", b_lru, 3'b100);
    chk("b_t0_again_victim", b_victim, 4'b0100);
    b_upd(2, 4'b1000);
    b_rd(2);
    chk("b_w3_lru", b_lru, 3'b101);
    chk("b_w3_victim", b_victim, 4'b0010);
    for (int s = 0; s < 8; s++) a_upd(3'(s), 2'b10);
    a_flush = 1;
    step();
    a_flush = 0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("busy_c%0d", i), a_busy, 1);
      if (i == 2) begin a_rd_en = 1; a_rd_idx = 7; end
      if (i == 3) begin a_flush = 1; a_upd_en = 1; a_upd_idx = 0; a_upd_way = 2'b10; end
      step();
      a_rd_en = 0; a_flush = 0; a_upd_en = 0;
      if (i == 2) chk("sweep_rd_lru", a_lru, 0);
    end
    chk("busy_end", a_busy, 0);
    for (int s = 0; s < 8; s++) begin
      a_rd(3'(s));
      chk($sformatf("flushed_%0d", s), a_lru, 0);
    end
    for (int s = 0; s < 8; s++) a_upd(3'(s), 2'b10);
    a_flush = 1;
    step();
    a_flush = 0;
    step();
    step();
    step();
    rst_n = 0; a_rd_en = 1; a_rd_idx = 7;
    step();
    rst_n = 1; a_rd_en = 0;
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_valid", a_valid, 0);
    step();
    chk("rst_mid_idle", a_busy, 0);
    for (int s = 0; s < 8; s++) begin
      a_rd(3'(s));
      chk($sformatf("rst_cleared_%0d", s), a_lru, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
